// File: rtl/cs_micro_sequencer_pkg.sv
// Shared encodings for the control-store micro-sequencer.
// COND codes, address-mux selects, FSM states and MIR field positions.
package cs_micro_sequencer_pkg;

  localparam int MIR_RD_BIT    = 19;
  localparam int MIR_WR_BIT    = 18;
  localparam int MIR_COND_HI   = 13;
  localparam int MIR_COND_LO   = 11;
  localparam int MIR_JADDR_HI  = 10;
  localparam int MIR_JADDR_LO  = 0;
  localparam int FLAG_N_BIT    = 3;
  localparam int FLAG_Z_BIT    = 2;
  localparam int FLAG_V_BIT    = 1;
  localparam int FLAG_C_BIT    = 0;

  typedef enum logic [2:0] {
    COND_CSAI   = 3'b000,
    COND_N      = 3'b001,
    COND_Z      = 3'b010,
    COND_V      = 3'b011,
    COND_C      = 3'b100,
    COND_IR13   = 3'b101,
    COND_JUMP   = 3'b110,
    COND_DECODE = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    SEL_CSAI    = 2'b00,
    SEL_MIR     = 2'b01,
    SEL_DECODER = 2'b10
  } sel_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_WAIT  = 2'b10
  } state_e;

  function automatic sel_e sel_if(input logic c);
    return c ? SEL_MIR : SEL_CSAI;
  endfunction

endpackage

// File: rtl/cs_micro_sequencer_cond_eval.sv
// CS_CS_COND_EVAL: combinational branch-condition evaluator.
// Ports: cond_i (COND), flags_i {N,Z,V,C}, ir13_i in; sel_o out.
module CS_CS_COND_EVAL
  import cs_micro_sequencer_pkg::*;
(
  input  cond_e      cond_i,
  input  logic [3:0] flags_i,
  input  logic       ir13_i,
  output sel_e       sel_o
);

  always_comb begin
    sel_o = SEL_CSAI;
    unique case (cond_i)
      COND_CSAI:   sel_o = SEL_CSAI;
      COND_N:      sel_o = sel_if(flags_i[FLAG_N_BIT]);
      COND_Z:      sel_o = sel_if(flags_i[FLAG_Z_BIT]);
      COND_V:      sel_o = sel_if(flags_i[FLAG_V_BIT]);
      COND_C:      sel_o = sel_if(flags_i[FLAG_C_BIT]);
      COND_IR13:   sel_o = sel_if(ir13_i);
      COND_JUMP:   sel_o = SEL_MIR;
      COND_DECODE: sel_o = SEL_DECODER;
      default:     sel_o = SEL_CSAI;
    endcase
  end

endmodule

// File: rtl/cs_micro_sequencer.sv
// Micro-sequencer: FETCH/EXEC(/WAIT) FSM driving control-store address,
// MIR and address-mux select. Ports: clock, sync reset, CSWord, MuxAddr,
// flags, IR13, MemReady (low) in; CSAddr, CSAI, MIR, Jump, select, Exec out.
// Macro CS_MICRO_SEQUENCER_MEMWAIT_EN adds the WAIT state / memory handshake.
module cs_micro_sequencer
  import cs_micro_sequencer_pkg::*;
#(
  parameter int ADDR_LENGTH      = 11,
  parameter int MIR_LENGTH       = 41,
  parameter int SELECTION_LENGTH = 2
) (
  input  logic                        CS_MICRO_SEQUENCER_CLOCK_50,
  input  logic                        CS_MICRO_SEQUENCER_RESET_InHigh,
  input  logic [MIR_LENGTH-1:0]       CS_MICRO_SEQUENCER_data_CSWord_InBUS,
  input  logic [ADDR_LENGTH-1:0]      CS_MICRO_SEQUENCER_data_MuxAddr_InBUS,
  input  logic [3:0]                  CS_MICRO_SEQUENCER_data_Flags_InBUS,
  input  logic                        CS_MICRO_SEQUENCER_data_IR13,
  input  logic                        CS_MICRO_SEQUENCER_MemReady_InLow,
  output logic [ADDR_LENGTH-1:0]      CS_MICRO_SEQUENCER_data_CSAddr_OutBUS,
  output logic [ADDR_LENGTH-1:0]      CS_MICRO_SEQUENCER_data_CSAI_OutBUS,
  output logic [MIR_LENGTH-1:0]       CS_MICRO_SEQUENCER_data_MIR_OutBUS,
  output logic [ADDR_LENGTH-1:0]      CS_MICRO_SEQUENCER_data_Jump_OutBUS,
  output logic [SELECTION_LENGTH-1:0] CS_MICRO_SEQUENCER_selection_OutBUS,
  output logic                        CS_MICRO_SEQUENCER_Exec_OutHigh
);

  state_e                 state_q;
  logic [ADDR_LENGTH-1:0] addr_q, addr_d;
  logic [ADDR_LENGTH-1:0] ai_q, ai_d;
  logic [MIR_LENGTH-1:0]  mir_q;
  logic                   exec_q;
  logic                   last_cyc;
  cond_e                  cond;
  sel_e                   sel_eval;

  assign cond = cond_e'(mir_q[MIR_COND_HI:MIR_COND_LO]);

  CS_CS_COND_EVAL u_cond_eval (
    .cond_i  (cond),
    .flags_i (CS_MICRO_SEQUENCER_data_Flags_InBUS),
    .ir13_i  (CS_MICRO_SEQUENCER_data_IR13),
    .sel_o   (sel_eval)
  );

  assign addr_d = CS_MICRO_SEQUENCER_data_MuxAddr_InBUS;
  assign ai_d   = addr_d + ADDR_LENGTH'(1);

`ifdef CS_MICRO_SEQUENCER_MEMWAIT_EN
  logic mem_op;
  logic mem_busy;
  assign mem_op   = mir_q[MIR_RD_BIT] | mir_q[MIR_WR_BIT];
  // MemReady is active-low: high means the access is still pending
  assign mem_busy = CS_MICRO_SEQUENCER_MemReady_InLow;
  assign last_cyc = ((state_q == ST_EXEC) && !(mem_op && mem_busy)) ||
                    ((state_q == ST_WAIT) && !mem_busy);
`else
  logic unused_mem_ready;
  assign unused_mem_ready = CS_MICRO_SEQUENCER_MemReady_InLow;
  assign last_cyc = (state_q == ST_EXEC);
`endif

  always_ff @(posedge CS_MICRO_SEQUENCER_CLOCK_50) begin
    if (CS_MICRO_SEQUENCER_RESET_InHigh) begin
      state_q <= ST_FETCH;
      addr_q  <= '0;
      ai_q    <= ADDR_LENGTH'(1);
      mir_q   <= '0;
      exec_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          mir_q   <= CS_MICRO_SEQUENCER_data_CSWord_InBUS;
          state_q <= ST_EXEC;
          exec_q  <= 1'b1;
        end
        ST_EXEC, ST_WAIT: begin
          if (last_cyc) begin
            state_q <= ST_FETCH;
            exec_q  <= 1'b0;
            addr_q  <= addr_d;
            ai_q    <= ai_d;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        default: begin
          state_q <= ST_FETCH;
          exec_q  <= 1'b0;
        end
      endcase
    end
  end

  assign CS_MICRO_SEQUENCER_data_CSAddr_OutBUS = addr_q;
  assign CS_MICRO_SEQUENCER_data_CSAI_OutBUS   = ai_q;
  assign CS_MICRO_SEQUENCER_data_MIR_OutBUS    = mir_q;
  assign CS_MICRO_SEQUENCER_data_Jump_OutBUS   =
    mir_q[MIR_JADDR_LO +: ADDR_LENGTH];
  // Select only meaningful once the MIR holds the current microinstruction
  assign CS_MICRO_SEQUENCER_selection_OutBUS   =
    SELECTION_LENGTH'((state_q == ST_FETCH) ? SEL_CSAI : sel_eval);
  assign CS_MICRO_SEQUENCER_Exec_OutHigh       = exec_q;

endmodule

// File: tb/tb_cs_micro_sequencer.sv
// Scoreboard bench for cs_micro_sequencer: directed microprogram in a
// ROM model, expected records queued by the driver, checked by a monitor.
module tb_cs_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [40:0] cs_word;
  logic [10:0] mux_addr;
  logic [3:0]  flags;
  logic        ir13;
  logic        ready_n;
  logic [10:0] cs_addr, csai, jump;
  logic [40:0] mir;
  logic [1:0]  sel;
  logic        exec;

  logic [40:0] rom [0:2047];
  logic [10:0] dec_addr;

  always #5 clk = ~clk;

  cs_micro_sequencer dut (
    .CS_MICRO_SEQUENCER_CLOCK_50          (clk),
    .CS_MICRO_SEQUENCER_RESET_InHigh      (rst),
    .CS_MICRO_SEQUENCER_data_CSWord_InBUS (cs_word),
    .CS_MICRO_SEQUENCER_data_MuxAddr_InBUS(mux_addr),
    .CS_MICRO_SEQUENCER_data_Flags_InBUS  (flags),
    .CS_MICRO_SEQUENCER_data_IR13         (ir13),
    .CS_MICRO_SEQUENCER_MemReady_InLow    (ready_n),
    .CS_MICRO_SEQUENCER_data_CSAddr_OutBUS(cs_addr),
    .CS_MICRO_SEQUENCER_data_CSAI_OutBUS  (csai),
    .CS_MICRO_SEQUENCER_data_MIR_OutBUS   (mir),
    .CS_MICRO_SEQUENCER_data_Jump_OutBUS  (jump),
    .CS_MICRO_SEQUENCER_selection_OutBUS  (sel),
    .CS_MICRO_SEQUENCER_Exec_OutHigh      (exec)
  );

  // Environment: control store and external address mux
  assign cs_word = rom[cs_addr];
  always_comb begin
    mux_addr = csai;
    if (sel == 2'b01) mux_addr = jump;
    else if (sel == 2'b10) mux_addr = dec_addr;
  end

  typedef struct {
    logic [10:0] addr;
    logic [40:0] word;
    logic [3:0]  flags;
    logic        ir13;
    logic [10:0] dec;
    int          hi;
    logic [1:0]  sel;
    logic [10:0] nxt;
    logic [10:0] nxt_ai;
  } step_t;

  typedef struct {
    logic [40:0] mir;
    logic [1:0]  sel;
    logic [10:0] jump;
    logic [10:0] nxt;
    logic [10:0] nxt_ai;
    int          cycles;
  } exp_t;

  step_t steps[$];
  exp_t  sb[$];
  int    n_chk = 0;
  int    n_fail = 0;
  logic  mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [40:0] mk(input logic rd, input logic wr,
                                     input logic [2:0] c,
                                     input logic [10:0] j);
    logic [40:0] w;
    w = '0;
    w[19] = rd;
    w[18] = wr;
    w[13:11] = c;
    w[10:0] = j;
    return w;
  endfunction

  task automatic add(input logic [10:0] a, input logic [40:0] w,
                     input logic [3:0] f, input logic i13,
                     input logic [10:0] d, input int hi,
                     input logic [1:0] s, input logic [10:0] n,
                     input logic [10:0] nai);
    step_t st;
    st.addr = a; st.word = w; st.flags = f; st.ir13 = i13;
    st.dec = d; st.hi = hi; st.sel = s; st.nxt = n; st.nxt_ai = nai;
    steps.push_back(st);
    rom[a] = w;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_csaddr"}, 64'(cs_addr), 64'h0);
    check({tag, "_csai"}, 64'(csai), 64'h1);
    check({tag, "_mir"}, 64'(mir), 64'h0);
    check({tag, "_sel"}, 64'(sel), 64'h0);
    check({tag, "_exec"}, 64'(exec), 64'h0);
  endtask

  // Monitor: pops one record per microinstruction
  initial begin
    logic        prev;
    logic        have;
    int          cnt;
    logic [10:0] start_addr;
    exp_t        cur;
    prev = 1'b0;
    have = 1'b0;
    cnt = 0;
    start_addr = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exec && !prev) begin
          if (sb.size() == 0) begin
            check("scoreboard_underflow", 64'(1), 64'(0));
            have = 1'b0;
          end else begin
            cur = sb.pop_front();
            have = 1'b1;
            cnt = 1;
            start_addr = cs_addr;
            check("mir", 64'(mir), 64'(cur.mir));
            check("sel", 64'(sel), 64'(cur.sel));
            check("jump", 64'(jump), 64'(cur.jump));
          end
        end else if (exec && prev && have) begin
          cnt++;
          check("sel_wait", 64'(sel), 64'(cur.sel));
          check("csaddr_frozen", 64'(cs_addr), 64'(start_addr));
        end else if (!exec && prev && have) begin
          check("exec_cycles", 64'(cnt), 64'(cur.cycles));
          check("next_csaddr", 64'(cs_addr), 64'(cur.nxt));
          check("next_csai", 64'(csai), 64'(cur.nxt_ai));
          have = 1'b0;
        end
      end
      prev = exec;
    end
  end

  // Driver
  initial begin
    exp_t e;
    int   cnt;
    int   guard;
    for (int i = 0; i < 2048; i++) rom[i] = '0;
    rst = 1'b1;
    flags = '0;
    ir13 = 1'b0;
    ready_n = 1'b0;
    dec_addr = '0;

    add(11'h000, '0, 4'h0, 0, 11'h0, 0, 2'b00, 11'h001, 11'h002);
    add(11'h001, '0, 4'h0, 0, 11'h0, 0, 2'b00, 11'h002, 11'h003);
    add(11'h002, '0, 4'h0, 0, 11'h0, 2, 2'b00, 11'h003, 11'h004);
    add(11'h003, mk(0, 0, 3'b010, 11'h40A), 4'b0100, 0, 11'h0, 0,
        2'b01, 11'h40A, 11'h40B);
    add(11'h40A, mk(0, 0, 3'b010, 11'h123), 4'b1011, 0, 11'h0, 0,
        2'b00, 11'h40B, 11'h40C);
    add(11'h40B, mk(0, 0, 3'b111, 11'h000), 4'h0, 0, 11'h4A8, 0,
        2'b10, 11'h4A8, 11'h4A9);
    add(11'h4A8, mk(0, 0, 3'b110, 11'h7FF), 4'h0, 0, 11'h0, 0,
        2'b01, 11'h7FF, 11'h000);
    add(11'h7FF, mk(1, 0, 3'b110, 11'h100), 4'h0, 0, 11'h0, 3,
        2'b01, 11'h100, 11'h101);
    add(11'h100, mk(0, 0, 3'b001, 11'h200), 4'b1000, 0, 11'h0, 0,
        2'b01, 11'h200, 11'h201);
    add(11'h200, mk(0, 0, 3'b011, 11'h300), 4'b1101, 0, 11'h0, 0,
        2'b00, 11'h201, 11'h202);
    add(11'h201, mk(0, 0, 3'b100, 11'h300), 4'b0001, 0, 11'h0, 0,
        2'b01, 11'h300, 11'h301);
    add(11'h300, mk(0, 0, 3'b101, 11'h350), 4'b0000, 1, 11'h0, 0,
        2'b01, 11'h350, 11'h351);
    add(11'h350, mk(0, 0, 3'b101, 11'h360), 4'b1111, 0, 11'h0, 0,
        2'b00, 11'h351, 11'h352);
    add(11'h351, mk(0, 1, 3'b000, 11'h7FF), 4'h0, 0, 11'h0, 1,
        2'b00, 11'h352, 11'h353);
    rom[11'h352] = mk(1, 0, 3'b110, 11'h555);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    foreach (steps[k]) begin
      flags = steps[k].flags;
      ir13 = steps[k].ir13;
      dec_addr = steps[k].dec;
      ready_n = (steps[k].hi > 0);
      e.mir = steps[k].word;
      e.sel = steps[k].sel;
      e.jump = steps[k].word[10:0];
      e.nxt = steps[k].nxt;
      e.nxt_ai = steps[k].nxt_ai;
      e.cycles = 1;
`ifdef CS_MICRO_SEQUENCER_MEMWAIT_EN
      if (steps[k].word[19] | steps[k].word[18])
        e.cycles = 1 + steps[k].hi;
`endif
      sb.push_back(e);
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!exec && guard < 20);
      if (!exec) check("timeout_exec_rise", 64'(0), 64'(1));
      cnt = 0;
      guard = 0;
      while (exec && guard < 50) begin
        cnt++;
        guard++;
        ready_n = (cnt <= steps[k].hi);
        @(negedge clk);
      end
      if (exec) check("timeout_exec_fall", 64'(1), 64'(0));
    end

    // Reset in the middle of a memory access
    #1 mon_en = 1'b0;
    ready_n = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!exec && guard < 20);
    if (!exec) check("timeout_rst_exec", 64'(0), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("midwait_rst");
    check("midwait_rst_jump", 64'(jump), 64'h0);
    rst = 1'b0;
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cs_micro_sequencer.md
CS_MICRO_SEQUENCER -- requirements
Module: CS_MICRO_SEQUENCER

Interface
REQ-001 Parameter ADDR_LENGTH, default 11: control-store address width.
REQ-002 Parameter MIR_LENGTH, default 41: microinstruction width.
REQ-003 Parameter SELECTION_LENGTH, default 2: address-mux select width.
REQ-004 CS_MICRO_SEQUENCER_CLOCK_50  in  1: sole clock; all state updates on the rising edge.
REQ-005 CS_MICRO_SEQUENCER_RESET_InHigh  in  1: reset, synchronous and active-high.
REQ-006 CS_MICRO_SEQUENCER_data_CSWord_InBUS  in  MIR_LENGTH: control-store read data, valid one cycle after the address is presented.
REQ-007 CS_MICRO_SEQUENCER_data_MuxAddr_InBUS  in  ADDR_LENGTH: next address returned by the address mux.
REQ-008 CS_MICRO_SEQUENCER_data_Flags_InBUS  in  4: PSR {N,Z,V,C}.
REQ-009 CS_MICRO_SEQUENCER_data_IR13  in  1: IR bit 13 (immediate flag).
REQ-010 CS_MICRO_SEQUENCER_MemReady_InLow  in  1: memory-done strobe, active-low.
REQ-011 CS_MICRO_SEQUENCER_data_CSAddr_OutBUS  out  ADDR_LENGTH: registered control-store read address.
REQ-012 CS_MICRO_SEQUENCER_data_CSAI_OutBUS  out  ADDR_LENGTH: registered incremented address, CSAddr+1.
REQ-013 CS_MICRO_SEQUENCER_data_MIR_OutBUS  out  MIR_LENGTH: registered microinstruction.
REQ-014 CS_MICRO_SEQUENCER_data_Jump_OutBUS  out  ADDR_LENGTH: MIR[10:0], the jump address.
REQ-015 CS_MICRO_SEQUENCER_selection_OutBUS  out  SELECTION_LENGTH: address-mux select.
REQ-016 CS_MICRO_SEQUENCER_Exec_OutHigh  out  1: MIR valid, datapath may act this cycle.

Function
REQ-017 MIR fields: RD=MIR[19], WR=MIR[18], COND=MIR[13:11], JADDR=MIR[10:0].
REQ-018 FSM states: FETCH, EXEC, WAIT; FETCH->EXEC unconditionally, with the MIR loaded from CSWord on that edge.
REQ-019 In EXEC, when RD|WR=1 and MemReady_InLow=1, the next state is WAIT, else FETCH.
REQ-020 WAIT holds until MemReady_InLow=0, then goes to FETCH; selection and Exec stay stable during WAIT.
REQ-021 Select, combinational from COND, valid in EXEC/WAIT only; default 2'b00 in FETCH.
REQ-022 COND 000 -> 00 (CSAI).
REQ-023 COND 001/010/011/100 -> 01 if N/Z/V/C respectively = 1, else 00.
REQ-024 COND 101 -> 01 if IR13=1, else 00.
REQ-025 COND 110 -> 01 (jump); COND 111 -> 10 (decode); 11 is never driven.
REQ-026 On the last EXEC/WAIT cycle, CSAddr<=MuxAddr_InBUS and CSAI<=MuxAddr_InBUS+1, modulo 2^ADDR_LENGTH (2047 wraps to 0).
REQ-027 Throughput: 2 cycles per microinstruction plus WAIT cycles.
REQ-028 Exec_OutHigh=1 exactly in EXEC and WAIT.
REQ-029 Flags and IR13 are sampled combinationally every EXEC/WAIT cycle; the value in the final cycle decides.

Reset
REQ-030 Reset has priority over all other inputs in every state, including mid-WAIT.
REQ-031 Reset values: state=FETCH, CSAddr=0, CSAI=1, MIR=0 (COND 000, no RD/WR), select=00, Exec=0.

Configuration
REQ-032 Macro CS_MICRO_SEQUENCER_MEMWAIT_EN defined: WAIT state and MemReady_InLow handshake present as in REQ-019..020.
REQ-033 Macro CS_MICRO_SEQUENCER_MEMWAIT_EN undefined: no WAIT state; EXEC always goes to FETCH; MemReady_InLow is ignored.

Structure
REQ-034 A shared package holds the COND encodings, select encodings (00 CSAI, 01 MIR, 10 DECODER), state encodings and MIR field bit positions.
REQ-035 One sub-module, CS_CS_COND_EVAL, is combinational: COND, flags and IR13 in, select out.

Verification
REQ-036 Reset then CSWord=0 -> CSAddr 0, then 1, then 2 every 2 cycles with MuxAddr looped from CSAI; select=00 throughout.
REQ-037 MIR COND=010, JADDR=0x40A, Z=1 -> select 01, next CSAddr=0x40A, CSAI=0x40B; repeat with Z=0 -> select 00.
REQ-038 COND=111, MuxAddr fed 0x4A8 -> select 10, CSAddr=0x4A8.
REQ-039 MEMWAIT_EN, RD=1, MemReady_InLow held high 3 cycles -> 3 WAIT cycles, Exec=1, CSAddr frozen; ready low -> FETCH next cycle.
REQ-040 MuxAddr=2047 -> CSAI=0; reset asserted mid-WAIT -> all REQ-031 values on the next edge.
